// File: rtl/spec_chan_occupancy.sv
// rtl/spec_chan_occupancy.sv - per-channel mean power with hysteresis busy flag over averaged spectrum bins
// Optional occ_map output enabled by `define SPEC_OCC_BITMAP_EN.
module spec_chan_occupancy #(
    parameter int SR_BASE        = 135,
    parameter int MAX_BINS_LOG2  = 6,
    parameter int MAX_CHANS_LOG2 = 8
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        err_short
`ifdef SPEC_OCC_BITMAP_EN
    ,
    output logic [(1<<MAX_CHANS_LOG2)-1:0] occ_map
`endif
);
    localparam int ACC_W = 32 + MAX_BINS_LOG2;
    localparam int CNT_W = MAX_BINS_LOG2;
    localparam int NCH   = 1 << MAX_CHANS_LOG2;
    localparam logic [7:0]  ADDR_BINS = 8'(SR_BASE);
    localparam logic [7:0]  ADDR_HI   = 8'(SR_BASE + 1);
    localparam logic [7:0]  ADDR_LO   = 8'(SR_BASE + 2);
    localparam logic [7:0]  ADDR_CLR  = 8'(SR_BASE + 3);
    localparam logic [3:0]  MAX_L2    = 4'(MAX_BINS_LOG2);
    localparam logic [30:0] MEAN_MAX  = '1;

    logic [3:0]                cfg_l2_q, act_l2_q, act_l2_d;
    logic [30:0]               thr_hi_q, thr_lo_q;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [CNT_W-1:0]          bin_cnt_q, bin_cnt_d;
    logic [MAX_CHANS_LOG2-1:0] chan_idx_q, chan_idx_d;
    logic [NCH-1:0]            busy_q, busy_d;
    logic [31:0]               o_tdata_q, o_tdata_d;
    logic                      o_tlast_q, o_tlast_d;
    logic                      o_tvalid_q, o_tvalid_d;
    logic                      err_q, err_d;

    logic             wr_bins, wr_hi, wr_lo, wr_clr;
    logic             beat, pkt_start, done, busy_new;
    logic [3:0]       eff_l2;
    logic [CNT_W:0]   one_hot;
    logic [CNT_W-1:0] last_cnt;
    logic [ACC_W-1:0] sum, shifted;
    logic [30:0]      mean;
    logic             unused_bits;

    assign unused_bits = set_data[31];

    assign wr_bins = set_stb && (set_addr == ADDR_BINS);
    assign wr_hi   = set_stb && (set_addr == ADDR_HI);
    assign wr_lo   = set_stb && (set_addr == ADDR_LO);
    assign wr_clr  = set_stb && (set_addr == ADDR_CLR);

    assign i_tready  = ~o_tvalid_q;
    assign o_tdata   = o_tdata_q;
    assign o_tlast   = o_tlast_q;
    assign o_tvalid  = o_tvalid_q;
    assign err_short = err_q;
`ifdef SPEC_OCC_BITMAP_EN
    assign occ_map   = busy_q;
`endif

    // The first beat of a packet already uses the freshly latched channel size.
    assign beat      = i_tvalid && i_tready;
    assign pkt_start = (bin_cnt_q == '0) && (chan_idx_q == '0);
    assign eff_l2    = pkt_start ? cfg_l2_q : act_l2_q;
    assign one_hot   = (CNT_W+1)'(1) << eff_l2;
    assign last_cnt  = CNT_W'(one_hot - 1'b1);
    assign sum       = acc_q + ACC_W'(i_tdata);
    assign shifted   = sum >> eff_l2;
    assign mean      = (|shifted[ACC_W-1:31]) ? MEAN_MAX : shifted[30:0];
    assign done      = beat && ((bin_cnt_q == last_cnt) || i_tlast);

    always_comb begin
        busy_new = busy_q[chan_idx_q];
        if (mean > thr_hi_q) begin
            busy_new = 1'b1;
        end else if (mean < thr_lo_q) begin
            busy_new = 1'b0;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        bin_cnt_d  = bin_cnt_q;
        chan_idx_d = chan_idx_q;
        busy_d     = busy_q;
        act_l2_d   = act_l2_q;
        o_tdata_d  = o_tdata_q;
        o_tlast_d  = o_tlast_q;
        o_tvalid_d = o_tvalid_q;
        err_d      = 1'b0;
        if (o_tvalid_q && o_tready) begin
            o_tvalid_d = 1'b0;
        end
        if (beat) begin
            if (pkt_start) begin
                act_l2_d = cfg_l2_q;
            end
            if (done) begin
                acc_d              = '0;
                bin_cnt_d          = '0;
                chan_idx_d         = i_tlast ? '0 : chan_idx_q + 1'b1;
                busy_d[chan_idx_q] = busy_new;
                o_tvalid_d         = 1'b1;
                o_tdata_d          = {busy_new, mean};
                o_tlast_d          = i_tlast;
                err_d              = i_tlast && (bin_cnt_q < last_cnt);
            end else begin
                acc_d     = sum;
                bin_cnt_d = bin_cnt_q + 1'b1;
            end
        end
        // Clear wins over the channel state but leaves the output word intact.
        if (wr_clr) begin
            acc_d      = '0;
            bin_cnt_d  = '0;
            chan_idx_d = '0;
            busy_d     = '0;
        end
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            cfg_l2_q   <= 4'd3;
            act_l2_q   <= 4'd3;
            thr_hi_q   <= MEAN_MAX;
            thr_lo_q   <= '0;
            acc_q      <= '0;
            bin_cnt_q  <= '0;
            chan_idx_q <= '0;
            busy_q     <= '0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
            o_tvalid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (wr_bins) begin
                cfg_l2_q <= (set_data[3:0] > MAX_L2) ? MAX_L2 : set_data[3:0];
            end
            if (wr_hi) begin
                thr_hi_q <= set_data[30:0];
            end
            if (wr_lo) begin
                thr_lo_q <= set_data[30:0];
            end
            act_l2_q   <= act_l2_d;
            acc_q      <= acc_d;
            bin_cnt_q  <= bin_cnt_d;
            chan_idx_q <= chan_idx_d;
            busy_q     <= busy_d;
            o_tdata_q  <= o_tdata_d;
            o_tlast_q  <= o_tlast_d;
            o_tvalid_q <= o_tvalid_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_spec_chan_occupancy.sv
// tb/tb_spec_chan_occupancy.sv - scoreboard bench for spec_chan_occupancy with a packet-level reference model
module tb_spec_chan_occupancy;
    localparam int SR_BASE = 135;

    logic        ce_clk = 1'b0;
    logic        ce_rst = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b0;
    logic        err_short;
`ifdef SPEC_OCC_BITMAP_EN
    logic [255:0] occ_map;
`endif

    always #5 ce_clk = ~ce_clk;

    spec_chan_occupancy #(.SR_BASE(SR_BASE), .MAX_BINS_LOG2(6), .MAX_CHANS_LOG2(8)) dut (
        .ce_clk(ce_clk), .ce_rst(ce_rst),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .err_short(err_short)
`ifdef SPEC_OCC_BITMAP_EN
        , .occ_map(occ_map)
`endif
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned pkt[$];
    int          checks = 0;
    int          failures = 0;
    int          m_l2 = 3;
    longint unsigned m_hi = 64'h7FFFFFFF;
    longint unsigned m_lo = 0;
    bit          m_busy[256];
    int          m_chan = 0;
    int          rdy_mode = 2;
    bit          seen = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_l2 = 3; m_hi = 64'h7FFFFFFF; m_lo = 0; m_chan = 0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
    endtask

    // Split the packet into 2^L-bin channels; a trailing short group only exists when the packet ends.
    task automatic model_pkt(input bit has_last);
        int n, sz, i, cnt;
        longint unsigned sum, mean;
        bit b;
        exp_t e;
        n = pkt.size(); sz = 1 << m_l2; i = 0;
        while (i < n) begin
            cnt = (n - i < sz) ? n - i : sz;
            if (cnt < sz && !has_last) break;
            sum = 0;
            for (int k = 0; k < cnt; k++) sum += pkt[i+k];
            mean = sum >> m_l2;
            if (mean > 64'h7FFFFFFF) mean = 64'h7FFFFFFF;
            if (mean > m_hi) b = 1'b1;
            else if (mean < m_lo) b = 1'b0;
            else b = m_busy[m_chan];
            m_busy[m_chan] = b;
            e.data = {b, mean[30:0]};
            e.last = has_last && (i + cnt == n);
            e.err  = (cnt < sz);
            exp_q.push_back(e);
            m_chan = (m_chan + 1) % 256;
            i += cnt;
        end
        if (has_last) m_chan = 0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        i_tdata = d; i_tlast = l; i_tvalid = 1'b1;
        @(negedge ce_clk);
        while (!i_tready && n < 200) begin
            @(negedge ce_clk);
            n++;
        end
        if (!i_tready) begin
            checks++; failures++;
            $display("FAIL beat_timeout: i_tready=0 after %0d cycles, required 1", n);
        end
        @(posedge ce_clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0;
    endtask

    task automatic drive_range(input int lo, input int hi, input bit has_last);
        for (int k = lo; k <= hi; k++) begin
            drive_beat(pkt[k], has_last && (k == hi));
            repeat ($urandom_range(0, 2)) begin
                @(posedge ce_clk); #1;
            end
        end
    endtask

    task automatic send(input bit has_last);
        model_pkt(has_last);
        drive_range(0, pkt.size() - 1, has_last);
    endtask

    task automatic fill(input int n, input int unsigned v);
        pkt.delete();
        for (int k = 0; k < n; k++) pkt.push_back(v);
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        set_stb = 1'b1; set_addr = 8'(SR_BASE + off); set_data = d;
        @(posedge ce_clk); #1;
        set_stb = 1'b0;
        case (off)
            0: m_l2 = (d[3:0] > 4'd6) ? 6 : int'(d[3:0]);
            1: m_hi = longint'(d[30:0]);
            2: m_lo = longint'(d[30:0]);
            default: begin
                m_chan = 0;
                foreach (m_busy[i]) m_busy[i] = 1'b0;
            end
        endcase
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_tvalid) && n < 2000) begin
            @(posedge ce_clk); #1;
            n++;
        end
        check({"drain_", tag}, exp_q.size(), 0);
    endtask

    task automatic check_occ(input string tag);
`ifdef SPEC_OCC_BITMAP_EN
        logic [255:0] v;
        for (int i = 0; i < 256; i++) v[i] = m_busy[i];
        checks++;
        if (occ_map !== v) begin
            failures++;
            $display("FAIL occ_map_%s: got 0x%0h expected 0x%0h", tag, occ_map, v);
        end
`else
        if (tag.len() == 0) $display("occ_map not built");
`endif
    endtask

    task automatic async_reset(input string tag);
        #2;
        ce_rst = 1'b1;
        #1;
        check({"rst_o_tvalid_", tag}, o_tvalid, 0);
        check({"rst_o_tdata_", tag}, o_tdata, 0);
        check({"rst_err_", tag}, err_short, 0);
        exp_q.delete();
        seen = 1'b0;
        model_reset();
        @(posedge ce_clk); #1;
        ce_rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge ce_clk); #1;
            case (rdy_mode)
                0: o_tready = ($urandom_range(0, 3) != 0);
                1: o_tready = 1'b0;
                default: o_tready = 1'b1;
            endcase
        end
    end

    // Monitor: every presented word is compared with the scoreboard head; popped on handshake.
    always @(negedge ce_clk) begin
        if (!ce_rst) begin
            if (o_tvalid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_word: got 0x%0h with no word expected", o_tdata);
                end else begin
                    check("o_tdata", o_tdata, exp_q[0].data);
                    check("o_tlast", o_tlast, exp_q[0].last);
                    if (seen) check("err_hold", err_short, 0);
                    else check("err_short", err_short, exp_q[0].err);
                    seen = 1'b1;
                    if (o_tready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end else begin
                check("err_idle", err_short, 0);
            end
        end
    end

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge ce_clk);
        #1;
        check("reset_o_tvalid", o_tvalid, 0);
        check("reset_o_tlast", o_tlast, 0);
        check("reset_o_tdata", o_tdata, 0);
        check("reset_err", err_short, 0);
        check("reset_i_tready", i_tready, 1);
        ce_rst = 1'b0;
        @(posedge ce_clk); #1;

        wr(0, 2); wr(1, 100); wr(2, 50);
        fill(8, 200); send(1); drain("two_words");
        fill(4, 200); send(1);
        fill(4, 70);  send(1);
        fill(4, 40);  send(1); drain("hyst");
        fill(4, 32'hFFFFFFFF); send(1); drain("sat");
        fill(6, 40); send(1); drain("short");
        check_occ("short");

        rdy_mode = 1;
        fill(8, 150);
        model_pkt(1);
        fork
            drive_range(0, 7, 1'b1);
            begin
                n = 0;
                while (!o_tvalid && n < 100) begin
                    @(negedge ce_clk);
                    n++;
                end
                for (int c = 0; c < 10; c++) begin
                    @(negedge ce_clk);
                    check("stall_o_tvalid", o_tvalid, 1);
                    check("stall_i_tready", i_tready, 0);
                end
                rdy_mode = 0;
            end
        join
        drain("stall");

        pkt.delete();
        pkt = '{120, 120, 120, 120, 30, 30};
        model_pkt(1'b0);
        drive_range(0, 3, 1'b0);
        wr(0, 1);
        drive_range(4, 5, 1'b0);
        drain("pre_clear");
        check_occ("pre_clear");
        wr(3, 0);
        @(posedge ce_clk); #1;
        check_occ("cleared");
        fill(4, 70); send(1); drain("post_clear");
        check_occ("post_clear");

        rdy_mode = 0;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 3) == 0) wr(0, $urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) wr(1, $urandom_range(0, 1200));
            if ($urandom_range(0, 2) == 0) wr(2, $urandom_range(0, 1200));
            if ($urandom_range(0, 9) == 0) wr(3, 0);
            pkt.delete();
            n = $urandom_range(1, 40);
            for (int k = 0; k < n; k++)
                pkt.push_back(($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 2000));
            send(1);
        end
        drain("random");
        check_occ("random");

        rdy_mode = 1;
        wr(0, 2);
        fill(4, 200); send(0);
        repeat (2) @(posedge ce_clk);
        #1;
        check("pending_before_rst", o_tvalid, 1);
        async_reset("pending");
        rdy_mode = 0;
        fill(2, 500); send(0);
        async_reset("midchan");
        fill(8, 300); send(1); drain("after_rst");
        check_occ("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
